// File: rtl/buffer_controller_if.sv
// Stream and RAM-port bundle for buffer_controller: producer/consumer valid-ready
// handshakes plus the address/enable/data lines of the attached dual-port RAM.
interface buffer_controller_if #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 14
) ();
    logic [RAM_WIDTH-1:0]     in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic [RAM_WIDTH-1:0]     out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [RAM_WIDTH-1:0]     ram_data_in;
    logic [RAM_ADDR_BITS-1:0] ram_write_address;
    logic                     ram_write_enable;
    logic [RAM_ADDR_BITS-1:0] ram_read_address;
    logic [RAM_WIDTH-1:0]     ram_data_out;

    // master is the controller side
    modport master (
        input  in_data, in_valid, out_ready, ram_data_out,
        output in_ready, out_data, out_valid,
        output ram_data_in, ram_write_address, ram_write_enable, ram_read_address
    );

    modport slave (
        output in_data, in_valid, out_ready, ram_data_out,
        input  in_ready, out_data, out_valid,
        input  ram_data_in, ram_write_address, ram_write_enable, ram_read_address
    );
endinterface

// File: rtl/buffer_controller.sv
// FIFO control stage for a dual-port RAM with one-cycle registered read.
// Optional BUFFER_CTRL_LEVEL_EN adds the level and almost_full outputs.
module buffer_controller #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 14
) (
    input  logic                   clock,
    input  logic                   reset_n,
    buffer_controller_if.master    bus,
    output logic                   overflow
`ifdef BUFFER_CTRL_LEVEL_EN
    ,
    output logic [RAM_ADDR_BITS:0] level,
    output logic                   almost_full
`endif
);
    localparam logic [RAM_ADDR_BITS:0] FULL_COUNT = {1'b1, {RAM_ADDR_BITS{1'b0}}};

    logic [RAM_ADDR_BITS-1:0] wr_ptr_reg;
    logic [RAM_ADDR_BITS-1:0] rd_ptr_reg;
    logic [RAM_ADDR_BITS:0]   count_reg;
    logic [RAM_ADDR_BITS:0]   count_next;
    logic [RAM_ADDR_BITS:0]   visible_reg;
    logic [RAM_ADDR_BITS:0]   visible_next;
    logic                     push_d1_reg;
    logic                     push_d2_reg;
    logic                     overflow_reg;
    logic [RAM_WIDTH-1:0]     out_word;

    logic in_ready_int;
    logic out_valid_int;
    logic push;
    logic pop;

    assign in_ready_int  = (count_reg != FULL_COUNT);
    assign out_valid_int = (visible_reg != '0);
    assign push          = bus.in_valid & in_ready_int;
    assign pop           = out_valid_int & bus.out_ready;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // A word becomes visible two edges after its push, so a read can never race its write.
    assign visible_next = visible_reg + (RAM_ADDR_BITS + 1)'(push_d2_reg)
                                      - (RAM_ADDR_BITS + 1)'(pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            visible_reg  <= '0;
            push_d1_reg  <= 1'b0;
            push_d2_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg   <= count_next;
            visible_reg <= visible_next;
            push_d1_reg <= push;
            push_d2_reg <= push_d1_reg;
            if (bus.in_valid && !in_ready_int) overflow_reg <= 1'b1;
        end
    end

    assign out_word              = bus.ram_data_out;
    assign bus.out_data          = out_word;
    assign bus.in_ready          = in_ready_int;
    assign bus.out_valid         = out_valid_int;
    assign bus.ram_data_in       = bus.in_data;
    assign bus.ram_write_enable  = push;
    assign bus.ram_write_address = wr_ptr_reg;
    // Lookahead on pop so the next word arrives the cycle after the pop.
    assign bus.ram_read_address  = rd_ptr_reg + RAM_ADDR_BITS'(pop);
    assign overflow              = overflow_reg;

`ifdef BUFFER_CTRL_LEVEL_EN
    localparam logic [RAM_ADDR_BITS:0] ALMOST_FULL_COUNT = FULL_COUNT - (RAM_ADDR_BITS + 1)'(4);

    logic almost_full_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            almost_full_reg <= 1'b0;
        end else begin
            almost_full_reg <= (count_next >= ALMOST_FULL_COUNT);
        end
    end

    assign level       = count_reg;
    assign almost_full = almost_full_reg;
`endif
endmodule

// File: tb/tb_buffer_controller.sv
// Bench for buffer_controller (depth 16) with an attached registered-read RAM,
// a queue-based reference model and directed literal checks.
module tb_buffer_controller;
    localparam int W  = 8;
    localparam int AB = 4;
    localparam int DEPTH = 16;

    logic clock;
    logic reset_n;
    logic overflow;
`ifdef BUFFER_CTRL_LEVEL_EN
    logic [AB:0] level;
    logic        almost_full;
`endif

    buffer_controller_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) bus ();

    buffer_controller #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .bus      (bus.master),
        .overflow (overflow)
`ifdef BUFFER_CTRL_LEVEL_EN
        ,
        .level       (level),
        .almost_full (almost_full)
`endif
    );

    // dual-port RAM: write and registered read, old data on same-address collision
    logic [W-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (bus.ram_write_enable) mem[bus.ram_write_address] <= bus.ram_data_in;
        bus.ram_data_out <= mem[bus.ram_read_address];
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: FIFO of (data, push edge index); a word is visible two edges after its push
    typedef struct {
        logic [W-1:0] data;
        int           ts;
    } ent_t;
    ent_t mq[$];
    int   cyc = 0;
    int   wr_count = 0;
    int   rd_count = 0;
    bit   m_ovf = 0;

    function automatic bit m_out_valid();
        return (mq.size() > 0) && (mq[0].ts + 2 <= cyc);
    endfunction

    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                wr_count = 0;
                rd_count = 0;
                m_ovf    = 0;
            end else begin
                bit pop_m;
                bit push_m;
                pop_m  = m_out_valid() && bus.out_ready;
                push_m = bus.in_valid && (mq.size() < DEPTH);
                if (bus.in_valid && !(mq.size() < DEPTH)) m_ovf = 1;
                cyc++;
                if (pop_m) begin
                    void'(mq.pop_front());
                    rd_count++;
                end
                if (push_m) begin
                    mq.push_back('{data: bus.in_data, ts: cyc});
                    wr_count++;
                end
            end
        end
    end

    // per-cycle compare against the model
    bit           prev_stall = 0;
    logic [W-1:0] prev_data  = '0;
    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_stall = 0;
            end else begin
                bit ev;
                bit er;
                ev = m_out_valid();
                er = (mq.size() != DEPTH);
                chk("in_ready", int'(bus.in_ready), int'(er));
                chk("out_valid", int'(bus.out_valid), int'(ev));
                chk("overflow", int'(overflow), int'(m_ovf));
                chk("wr_en", int'(bus.ram_write_enable), int'(bus.in_valid && er));
                if (bus.in_valid && er) begin
                    chk("wr_addr", int'(bus.ram_write_address), wr_count % DEPTH);
                    chk("wr_data", int'(bus.ram_data_in), int'(bus.in_data));
                end
                chk("rd_addr", int'(bus.ram_read_address), (rd_count + int'(ev && bus.out_ready)) % DEPTH);
                if (ev) chk("out_data", int'(bus.out_data), int'(mq[0].data));
                if (prev_stall) chk("stall_hold", int'(bus.out_data), int'(prev_data));
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input int n);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (n) tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic fill(input int n, input int base);
        bus.out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'(base + i);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int pops;
        int bubbles;
        bit seen;
        int tx;
        int rx;
        int guard;

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_rd_addr", int'(bus.ram_read_address), 0);
        reset_n = 1'b1;
        tick();

        // single word latency
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clock);
        chk("lat_edge1_valid", int'(bus.out_valid), 0);
        tick();
        @(negedge clock);
        chk("lat_edge2_valid", int'(bus.out_valid), 0);
        tick();
        @(negedge clock);
        chk("lat_edge3_valid", int'(bus.out_valid), 1);
        chk("lat_data", int'(bus.out_data), 8'hA5);
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        @(negedge clock);
        chk("pop_empty_valid", int'(bus.out_valid), 0);
        chk("pop_empty_ready", int'(bus.in_ready), 1);
        tick();

        // fill to full, then one overflow attempt
        fill(16, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        @(negedge clock);
        chk("full_in_ready", int'(bus.in_ready), 0);
        chk("full_no_write", int'(bus.ram_write_enable), 0);
        chk("full_first_data", int'(bus.out_data), 0);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clock);
        chk("overflow_set", int'(overflow), 1);
        tick();
        drain(20);
        @(negedge clock);
        chk("drained_valid", int'(bus.out_valid), 0);
        tick();

        // full with simultaneous push and pop
        fill(16, 8'h20);
        tick();
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h77;
        bus.out_ready = 1'b1;
        @(negedge clock);
        chk("fpp_in_ready", int'(bus.in_ready), 0);
        chk("fpp_no_write", int'(bus.ram_write_enable), 0);
        chk("fpp_head", int'(bus.out_data), 8'h20);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clock);
        chk("fpp_ready_after", int'(bus.in_ready), 1);
        chk("fpp_next_head", int'(bus.out_data), 8'h21);
        tick();
        drain(20);

        // sustained push + pop
        pops = 0;
        bubbles = 0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = W'(i);
            bus.out_ready = 1'b1;
            @(negedge clock);
            if (bus.out_valid) begin
                pops++;
                seen = 1;
            end else if (seen) begin
                bubbles++;
            end
            tick();
        end
        chk("stream_pops", pops, 97);
        chk("stream_bubbles", bubbles, 0);
        drain(10);

        // random stalls, 1000 words
        tx = 0;
        rx = 0;
        guard = 0;
        while ((rx < 1000) && (guard < 20000)) begin
            bus.in_valid  = (tx < 1000) && ($urandom_range(3) != 0);
            bus.in_data   = W'(tx);
            bus.out_ready = ($urandom_range(2) != 0);
            @(negedge clock);
            if (bus.in_valid && bus.in_ready) tx++;
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_data", int'(bus.out_data), rx % 256);
                rx++;
            end
            tick();
            guard++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("sb_rx_total", rx, 1000);
        chk("sb_tx_total", tx, 1000);
        tick();

        // reset with 7 words stored
        fill(7, 8'h40);
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(bus.out_valid), 0);
        chk("mid_rst_ready", int'(bus.in_ready), 1);
        chk("mid_rst_ovf", int'(overflow), 0);
        chk("mid_rst_wr_en", int'(bus.ram_write_enable), 0);
        chk("mid_rst_rd_addr", int'(bus.ram_read_address), 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C;
        @(negedge clock);
        chk("post_rst_wr_addr", int'(bus.ram_write_address), 0);
        chk("post_rst_wr_en", int'(bus.ram_write_enable), 1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clock);
        chk("post_rst_hidden", int'(bus.out_valid), 0);
        tick();
        @(negedge clock);
        chk("post_rst_hidden2", int'(bus.out_valid), 0);
        tick();
        @(negedge clock);
        chk("post_rst_valid", int'(bus.out_valid), 1);
        chk("post_rst_data", int'(bus.out_data), 8'h3C);
        tick();
        drain(5);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/buffer_controller.md
# buffer_controller

FIFO control stage in front of the `dual_port_ram` buffer: converts a valid/ready producer stream and a valid/ready consumer stream into RAM write/read address and enable signals. It tracks fill level and hides the RAM's one-cycle registered read latency. It sits between the receive-side framing logic (upstream) and the buffer RAM plus transmit logic (downstream), sustaining one word per clock in each direction.

## Interface
- RAM_WIDTH, 8, data word width; must match the buffer RAM
- RAM_ADDR_BITS, 14, RAM address width; depth = 2**RAM_ADDR_BITS words
- clock  input  1  single clock, rising-edge
- reset_n  input  1  asynchronous, active-low reset
- in_data  input  RAM_WIDTH  producer word
- in_valid  input  1  producer word present
- in_ready  output  1  buffer can accept; high when not full
- out_data  output  RAM_WIDTH  consumer word; driven straight from ram_data_out
- out_valid  output  1  out_data holds the oldest stored word
- out_ready  input  1  consumer accepts
- ram_data_in  output  RAM_WIDTH  to RAM data_in; equals in_data
- ram_write_address  output  RAM_ADDR_BITS  to RAM write_address
- ram_write_enable  output  1  to RAM write_enable
- ram_read_address  output  RAM_ADDR_BITS  to RAM read_address
- ram_data_out  input  RAM_WIDTH  from RAM data_out; one-cycle registered read
- overflow  output  1  sticky; set when in_valid is high while in_ready is low

## Operation
- Push = in_valid & in_ready.
- Pop = out_valid & out_ready.
- ram_write_enable = push.
- ram_write_address = wr_ptr. wr_ptr increments on push and wraps from 2**RAM_ADDR_BITS-1 to 0.
- rd_ptr increments on pop and wraps the same way.
- ram_read_address = rd_ptr + pop (combinational lookahead, mod depth). This presents the next word one cycle after pop, so there is no bubble.
- count has RAM_ADDR_BITS+1 bits and updates as follows:
  - +1 on push only
  - −1 on pop only
  - unchanged on both or neither
- in_ready = (count != 2**RAM_ADDR_BITS).
- out_valid comes from a registered "visible" count. It excludes any word written in the immediately preceding cycle, because the RAM reads old data on a same-address write.
- A word pushed into an empty buffer at edge t first shows out_valid=1 and out_data at edge t+2.
- Full: push is blocked. A pop while full frees a slot, and in_ready rises the next cycle.
- Empty: out_valid=0, and out_data is don't-care. A push and no pop at the same time is legal.
- Simultaneous push and pop at any non-empty, non-full level: both occur and count holds.
- Consumer stall (out_ready=0): out_data must remain stable while out_valid=1. This is guaranteed because read_address is held and the occupied slot is never written.
- overflow clears only on reset.

## Timing
- Reset (reset_n low, asynchronous) sets:
  - wr_ptr, rd_ptr and count to 0
  - out_valid=0, overflow=0
  - in_ready=1, ram_write_enable=0, ram_read_address=0
- Reset mid-operation discards all contents. The first push after reset_n rises writes address 0.
- Latency from push to out_valid: 2 cycles when the buffer is empty. Otherwise the word is available once all older words are popped.
- Throughput: 1 push plus 1 pop per cycle sustained, with no idle cycles.
- in_ready and out_valid are registered-state-derived and do not depend combinationally on in_valid or out_ready.

## Configuration
- BUFFER_CTRL_LEVEL_EN defined:
  - Adds output `level` [RAM_ADDR_BITS:0], equal to count, registered and updated at the same edge as count.
  - Adds output `almost_full`, high when count ≥ 2**RAM_ADDR_BITS − 4.
  - Both reset to 0.
- Not defined: neither port exists, and there is no extra logic.

## Test plan
Bench uses RAM_ADDR_BITS=4 (depth 16) with a `dual_port_ram` instance attached.
- Reset, then a single push of 0xA5 → out_valid rises exactly 2 cycles after the push edge with out_data=0xA5. After a pop, out_valid=0 and count=0.
- 16 pushes of 0x00..0x0F with out_ready=0 → in_ready=0 after the 16th push. A 17th in_valid sets overflow=1 and no write occurs. Draining then yields 0x00..0x0F in order.
- Continuous push and pop, in_valid=out_ready=1 for 100 cycles, ascending data → zero bubbles on out_valid after the initial 2 cycles, data in order, and wrap past address 15 is seamless.
- Full buffer with push and pop in the same cycle → the pop succeeds, the push is blocked that cycle, and in_ready=1 on the next cycle.
- Random out_ready stalls → out_data is stable across every stalled cycle. A scoreboard sees no loss or duplication over 1000 words.
- reset_n pulled low with 7 words stored → all outputs reach their reset values immediately. The next push writes address 0, and old data is never presented.
